// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-client RAM port arbiter.
// State encodings, client indices and burst counter width.
// Imported by the controller and the top level.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  localparam int CLI_A = 0;
  localparam int CLI_B = 1;

  typedef enum logic [1:0] {
    A_PRI  = 2'd0,
    B_PRI  = 2'd1,
    A_LOCK = 2'd2,
    B_LOCK = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_dp_1024x8_ctl.sv
// Arbitration decision: grant vector plus next state/burst count.
// Purely combinational; the state and count registers live in the top.
// A locked owner excludes the other client even while idle.
module mem_arb_dp_1024x8_ctl
  import mem_arb_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             lock_a,
  input  logic             lock_b,
  input  logic [1:0]       state_q,
  input  logic [CNT_W-1:0] cnt_q,
  output logic [1:0]       gnt,
  output logic [1:0]       state_d,
  output logic [CNT_W-1:0] cnt_d
);

  localparam logic [CNT_W:0] BMAX = BURST_MAX[CNT_W:0];

  arb_state_e       st;
  arb_state_e       st_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic             burst_done;
  logic [CNT_W-1:0] cnt_sat;

  assign st      = arb_state_e'(state_q);
  assign state_d = st_nxt;

  // Burst accounting; a saturated counter also counts as an exhausted burst
  // so a client that joins late is never starved.
  always_comb begin
    cnt_inc    = {1'b0, cnt_q} + 1'b1;
    burst_done = (cnt_inc >= BMAX);
    cnt_sat    = (cnt_inc > BMAX) ? BMAX[CNT_W-1:0] : cnt_inc[CNT_W-1:0];
  end

  // Next-state and burst counter update
  always_comb begin
    st_nxt = st;
    cnt_d  = cnt_q;
    unique case (st)
      A_PRI: begin
        if (req_a) begin
          if (lock_a) begin
            st_nxt = A_LOCK;
            cnt_d  = '0;
          end else if (req_b && burst_done) begin
            st_nxt = B_PRI;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end else if (req_b) begin
          st_nxt = lock_b ? B_LOCK : B_PRI;
          cnt_d  = lock_b ? '0 : CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      B_PRI: begin
        if (req_b) begin
          if (lock_b) begin
            st_nxt = B_LOCK;
            cnt_d  = '0;
          end else if (req_a && burst_done) begin
            st_nxt = A_PRI;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end else if (req_a) begin
          st_nxt = lock_a ? A_LOCK : A_PRI;
          cnt_d  = lock_a ? '0 : CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      A_LOCK: begin
        cnt_d = '0;
        if (req_a && !lock_a) st_nxt = B_PRI;
      end
      B_LOCK: begin
        cnt_d = '0;
        if (req_b && !lock_b) st_nxt = A_PRI;
      end
      default: begin
        st_nxt = A_PRI;
        cnt_d  = '0;
      end
    endcase
  end

  // Grant outputs: priority owner first, the other only when owner is idle
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (st)
        A_PRI: begin
          gnt[CLI_A] = req_a;
          gnt[CLI_B] = req_b && !req_a;
        end
        B_PRI: begin
          gnt[CLI_B] = req_b;
          gnt[CLI_A] = req_a && !req_b;
        end
        A_LOCK:  gnt[CLI_A] = req_a;
        B_LOCK:  gnt[CLI_B] = req_b;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_arb_dp_1024x8.sv
// Round-robin arbiter with burst limit and lock sharing one RAM port.
// Grant/RAM port combinational; read data returned one cycle after grant.
// Losing client holds its request until granted; no internal buffering.
module mem_arb_dp_1024x8
  import mem_arb_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic       i_wen_a,
  input  logic       i_wen_b,
  input  logic       i_lock_a,
  input  logic       i_lock_b,
  input  logic [9:0] i_adr_a,
  input  logic [9:0] i_adr_b,
  input  logic [7:0] i_wdata_a,
  input  logic [7:0] i_wdata_b,
  output logic       o_gnt_a,
  output logic       o_gnt_b,
  output logic       o_rvalid_a,
  output logic       o_rvalid_b,
  output logic [7:0] o_rdata_a,
  output logic [7:0] o_rdata_b,
  output logic       o_mem_en,
  output logic       o_mem_wen,
  output logic [9:0] o_mem_adr,
  output logic [7:0] o_mem_wdata,
  input  logic [7:0] i_mem_rdata
);

  logic [1:0]       gnt;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvalid_a_q, rvalid_a_d;
  logic             rvalid_b_q, rvalid_b_d;

  mem_arb_dp_1024x8_ctl #(
    .BURST_MAX(BURST_MAX)
  ) u_ctl (
    .rst     (rst),
    .req_a   (i_req_a),
    .req_b   (i_req_b),
    .lock_a  (i_lock_a),
    .lock_b  (i_lock_b),
    .state_q (state_q),
    .cnt_q   (cnt_q),
    .gnt     (gnt),
    .state_d (state_d),
    .cnt_d   (cnt_d)
  );

  assign o_gnt_a = gnt[CLI_A];
  assign o_gnt_b = gnt[CLI_B];

  // Arbiter state register; reset also drops any held lock
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_PRI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Steer the winning client onto the RAM port
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_adr   = '0;
    o_mem_wdata = '0;
    if (gnt[CLI_A]) begin
      o_mem_en    = 1'b1;
      o_mem_wen   = i_wen_a;
      o_mem_adr   = i_adr_a;
      o_mem_wdata = i_wdata_a;
    end else if (gnt[CLI_B]) begin
      o_mem_en    = 1'b1;
      o_mem_wen   = i_wen_b;
      o_mem_adr   = i_adr_b;
      o_mem_wdata = i_wdata_b;
    end
  end

  // A granted read returns data on the following cycle
  always_comb begin
    rvalid_a_d = gnt[CLI_A] && !i_wen_a;
    rvalid_b_d = gnt[CLI_B] && !i_wen_b;
  end

  // Read-return flags, one pulse per granted read
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  // Masking with rst kills the return of a read granted just before reset
  assign o_rvalid_a = rvalid_a_q && !rst;
  assign o_rvalid_b = rvalid_b_q && !rst;
  assign o_rdata_a  = o_rvalid_a ? i_mem_rdata : 8'h00;
  assign o_rdata_b  = o_rvalid_b ? i_mem_rdata : 8'h00;

endmodule

// File: tb/tb_mem_arb_dp_1024x8.sv
// Scoreboard bench for mem_arb_dp_1024x8 with a behavioural RAM on the port.
// dut0 uses BURST_MAX=4; dut1 uses BURST_MAX=1 and is checked in its own phase.
module tb_mem_arb_dp_1024x8;

  localparam int NG = 0;
  localparam int GA = 1;
  localparam int GB = 2;

  // Unwritten RAM locations read as address[7:0] ^ 8'hA5
  localparam logic [7:0] D10  = 8'hB5;
  localparam logic [7:0] D20  = 8'h85;
  localparam logic [7:0] D30  = 8'h95;
  localparam logic [7:0] D3FF = 8'h5A;

  typedef struct { int cyc; int cli; } g_t;
  typedef struct { int cyc; int cli; logic [7:0] dat; } r_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_a, wen_a, lock_a, req_b, wen_b, lock_b;
  logic [9:0] adr_a, adr_b;
  logic [7:0] wd_a, wd_b;

  logic       gnt_a, gnt_b, rv_a, rv_b, mem_en, mem_wen;
  logic [7:0] rd_a, rd_b, mem_wd, mem_rd;
  logic [9:0] mem_adr;

  logic       g1_a, g1_b, rv1_a, rv1_b, mem_en1, mem_wen1;
  logic [7:0] rd1_a, rd1_b, mem_wd1;
  logic [9:0] mem_adr1;

  int cyc;
  int n_cmp;
  int n_bad;
  logic chk1;
  logic no_rv;

  g_t gq[$];
  g_t g1q[$];
  r_t rq[$];

  mem_arb_dp_1024x8 #(.BURST_MAX(4)) dut0 (
    .clk(clk), .rst(rst),
    .i_req_a(req_a), .i_req_b(req_b), .i_wen_a(wen_a), .i_wen_b(wen_b),
    .i_lock_a(lock_a), .i_lock_b(lock_b), .i_adr_a(adr_a), .i_adr_b(adr_b),
    .i_wdata_a(wd_a), .i_wdata_b(wd_b),
    .o_gnt_a(gnt_a), .o_gnt_b(gnt_b), .o_rvalid_a(rv_a), .o_rvalid_b(rv_b),
    .o_rdata_a(rd_a), .o_rdata_b(rd_b), .o_mem_en(mem_en), .o_mem_wen(mem_wen),
    .o_mem_adr(mem_adr), .o_mem_wdata(mem_wd), .i_mem_rdata(mem_rd)
  );

  mem_arb_dp_1024x8 #(.BURST_MAX(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req_a(req_a), .i_req_b(req_b), .i_wen_a(wen_a), .i_wen_b(wen_b),
    .i_lock_a(lock_a), .i_lock_b(lock_b), .i_adr_a(adr_a), .i_adr_b(adr_b),
    .i_wdata_a(wd_a), .i_wdata_b(wd_b),
    .o_gnt_a(g1_a), .o_gnt_b(g1_b), .o_rvalid_a(rv1_a), .o_rvalid_b(rv1_b),
    .o_rdata_a(rd1_a), .o_rdata_b(rd1_b), .o_mem_en(mem_en1), .o_mem_wen(mem_wen1),
    .o_mem_adr(mem_adr1), .o_mem_wdata(mem_wd1), .i_mem_rdata(8'h00)
  );

  // Behavioural RAM port for dut0: write-at-edge, registered read
  logic [7:0]    mem [1024];
  logic [1023:0] wr_mask;
  always @(posedge clk) begin
    if (rst) wr_mask <= '0;
    else if (mem_en && mem_wen) begin
      mem[mem_adr]     <= mem_wd;
      wr_mask[mem_adr] <= 1'b1;
    end
    if (mem_en && !mem_wen)
      mem_rd <= wr_mask[mem_adr] ? mem[mem_adr] : (mem_adr[7:0] ^ 8'hA5);
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever a DUT presents a grant or read data
  always @(negedge clk) begin
    int cli;
    g_t g;
    r_t r;
    if (gnt_a || gnt_b) begin
      cli = gnt_a ? 0 : 1;
      check("gnt_onehot", int'(gnt_a && gnt_b), 0);
      check("mem_en_on_gnt", int'(mem_en), 1);
      check("mem_adr", int'(mem_adr), int'(cli == 0 ? adr_a : adr_b));
      check("mem_wen", int'(mem_wen), int'(cli == 0 ? wen_a : wen_b));
      check("mem_wdata", int'(mem_wd), int'(cli == 0 ? wd_a : wd_b));
      if (gq.size() == 0) check("gnt_unexpected", cli, -1);
      else begin
        g = gq.pop_front();
        check("gnt_cycle", cyc, g.cyc);
        check("gnt_client", cli, g.cli);
      end
    end
    if (rv_a || rv_b) begin
      cli = rv_a ? 0 : 1;
      check("rvalid_onehot", int'(rv_a && rv_b), 0);
      check("rdata_idle_zero", int'(cli == 0 ? rd_b : rd_a), 0);
      if (rq.size() == 0) check("rvalid_unexpected", cli, -1);
      else begin
        r = rq.pop_front();
        check("rvalid_cycle", cyc, r.cyc);
        check("rvalid_client", cli, r.cli);
        check("rdata", int'(cli == 0 ? rd_a : rd_b), int'(r.dat));
      end
    end
    if (chk1 && (g1_a || g1_b)) begin
      cli = g1_a ? 0 : 1;
      check("b1_mem_en", int'(mem_en1), 1);
      check("b1_mem_wen", int'(mem_wen1), 0);
      check("b1_mem_adr", int'(mem_adr1), int'(cli == 0 ? adr_a : adr_b));
      check("b1_mem_wdata", int'(mem_wd1), int'(cli == 0 ? wd_a : wd_b));
      if (g1q.size() == 0) check("b1_gnt_unexpected", cli, -1);
      else begin
        g = g1q.pop_front();
        check("b1_gnt_cycle", cyc, g.cyc);
        check("b1_gnt_client", cli, g.cli);
      end
    end
  end

  // One cycle of stimulus plus the expectations it implies
  task automatic step(input logic ra, input logic wa, input logic la,
                      input logic [9:0] aa, input logic [7:0] da,
                      input logic rb, input logic wb, input logic lb,
                      input logic [9:0] ab, input logic [7:0] db,
                      input int eg, input int eg1, input logic [7:0] ed);
    g_t g;
    r_t r;
    req_a = ra; wen_a = wa; lock_a = la; adr_a = aa; wd_a = da;
    req_b = rb; wen_b = wb; lock_b = lb; adr_b = ab; wd_b = db;
    if (eg != NG) begin
      g.cyc = cyc;
      g.cli = eg - 1;
      gq.push_back(g);
      if (!(eg == GA ? wa : wb) && !no_rv) begin
        r.cyc = cyc + 1;
        r.cli = eg - 1;
        r.dat = ed;
        rq.push_back(r);
      end
    end
    if (chk1 && eg1 != NG) begin
      g.cyc = cyc;
      g.cli = eg1 - 1;
      g1q.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic ra, input logic [9:0] aa,
                    input logic rb, input logic [9:0] ab,
                    input int eg, input int eg1, input logic [7:0] ed);
    step(ra, 1'b0, 1'b0, aa, 8'h00, rb, 1'b0, 1'b0, ab, 8'h00, eg, eg1, ed);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(1'b0, 10'h0, 1'b0, 10'h0, NG, NG, 8'h00);
  endtask

  // One reset cycle with the given requests presented; outputs must be quiet
  task automatic rst_cyc(input logic ra, input logic rb);
    rst = 1'b1;
    req_a = ra; wen_a = 1'b0; lock_a = 1'b0; adr_a = 10'h010; wd_a = 8'h00;
    req_b = rb; wen_b = 1'b0; lock_b = 1'b0; adr_b = 10'h020; wd_b = 8'h00;
    @(negedge clk);
    check("rst_gnt_a", int'(gnt_a), 0);
    check("rst_gnt_b", int'(gnt_b), 0);
    check("rst_mem_en", int'(mem_en), 0);
    check("rst_mem_wen", int'(mem_wen), 0);
    check("rst_rvalid_a", int'(rv_a), 0);
    check("rst_rvalid_b", int'(rv_b), 0);
    check("rst_rdata_a", int'(rd_a), 0);
    check("rst_rdata_b", int'(rd_b), 0);
    check("rst_b1_gnt", int'(g1_a || g1_b), 0);
    check("rst_b1_mem_en", int'(mem_en1), 0);
    check("rst_b1_rvalid", int'(rv1_a || rv1_b), 0);
    check("rst_b1_rdata", int'(rd1_a | rd1_b), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk1 = 1'b0; no_rv = 1'b0;
    rst = 1'b1;
    req_a = 0; wen_a = 0; lock_a = 0; adr_a = 0; wd_a = 0;
    req_b = 0; wen_b = 0; lock_b = 0; adr_b = 0; wd_b = 0;
    @(posedge clk);
    #1;
    rst_cyc(1'b1, 1'b1);
    rst_cyc(1'b1, 1'b1);

    // Write 0x3C to address 5, then read it back
    step(1'b1, 1'b1, 1'b0, 10'd5, 8'h3C, 1'b0, 1'b0, 1'b0, 10'd0, 8'h00, GA, NG, 8'h00);
    rd(1'b1, 10'd5, 1'b0, 10'd0, GA, NG, 8'h3C);
    idle(2);

    // Contention with BURST_MAX=4: A A A A B B B B A
    rst_cyc(1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      rd(1'b1, 10'h010, 1'b1, 10'h020, (i < 4 || i == 8) ? GA : GB, NG,
         (i < 4 || i == 8) ? D10 : D20);
    idle(2);

    // B alone: ten back-to-back grants, counter saturates, no switch
    rst_cyc(1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      rd(1'b0, 10'h000, 1'b1, 10'h030, GB, NG, D30);
    idle(2);

    // Lock: B locked out until the cycle after A's unlocking write
    rst_cyc(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 10'h3FF, 8'h00, 1'b1, 1'b0, 1'b0, 10'h020, 8'h00, GA, NG, D3FF);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 10'h020, 8'h00, NG, NG, 8'h00);
    step(1'b1, 1'b1, 1'b0, 10'h3FF, 8'h77, 1'b1, 1'b0, 1'b0, 10'h020, 8'h00, GA, NG, 8'h00);
    rd(1'b0, 10'h000, 1'b1, 10'h020, GB, NG, D20);
    idle(2);

    // Reset right after A's last burst read: its return is dropped and
    // priority goes back to A even though B was due next
    rst_cyc(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      no_rv = (i == 3);
      rd(1'b1, 10'h010, 1'b1, 10'h020, GA, NG, D10);
    end
    no_rv = 1'b0;
    rst_cyc(1'b1, 1'b1);
    rd(1'b1, 10'h010, 1'b1, 10'h020, GA, NG, D10);
    idle(2);

    // BURST_MAX=1 alternates A B A B; dut0 still bursts in fours
    rst_cyc(1'b0, 1'b0);
    chk1 = 1'b1;
    for (int i = 0; i < 6; i++)
      rd(1'b1, 10'h010, 1'b1, 10'h020, (i < 4) ? GA : GB, (i % 2 == 0) ? GA : GB,
         (i < 4) ? D10 : D20);
    chk1 = 1'b0;
    idle(2);

    check("gnt_queue_drained", gq.size(), 0);
    check("rd_queue_drained", rq.size(), 0);
    check("b1_queue_drained", g1q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arb_dp_1024x8.md
# mem_arb_dp_1024x8

Two-client arbiter that shares one port of a 1024x8 dual-port block RAM between requesters A and B. It applies round-robin arbitration with a bounded burst length and supports a lock for atomic read-modify-write sequences. It sits between two client engines and one port of `xil_mem_dp_1024x8`; the other RAM port stays with its own owner.

## Interface
- `BURST_MAX`, 4: max consecutive grants to one client while the other is requesting; legal range 1..15.
- `clk` in 1: single clock. Also drives the RAM port clock.
- `rst` in 1: synchronous, active-high reset.
- `i_req_a` / `i_req_b` in 1: access request. Held until granted.
- `i_wen_a` / `i_wen_b` in 1: 1 = write, 0 = read.
- `i_lock_a` / `i_lock_b` in 1: keep ownership after this access.
- `i_adr_a` / `i_adr_b` in 10: byte address.
- `i_wdata_a` / `i_wdata_b` in 8: write data.
- `o_gnt_a` / `o_gnt_b` out 1: access accepted this cycle. Combinational from request and state.
- `o_rvalid_a` / `o_rvalid_b` out 1: read data valid. Registered.
- `o_rdata_a` / `o_rdata_b` out 8: read data. Equal to `i_mem_rdata` when the matching rvalid is high, otherwise 0.
- `o_mem_en`, `o_mem_wen` out 1: RAM port enable and write enable.
- `o_mem_adr` out 10, `o_mem_wdata` out 8: RAM port address and write data.
- `i_mem_rdata` in 8: RAM port read data. Valid the cycle after an enabled read.

## Operation
- Handshake: an access transfers on a cycle where req and gnt are both high. The request signals stay stable until then.
- At most one grant per cycle.
- On a grant, the winner's wen/adr/wdata drive the RAM port combinationally and `o_mem_en` = 1.
- With no grant, `o_mem_en` = 0 and `o_mem_wen` = 0.
- State machine has four states: A_PRI, B_PRI, A_LOCK, B_LOCK. A 4-bit burst counter `cnt` tracks consecutive grants.
- X_PRI, X requesting:
  - Grant X.
  - If `i_lock_X` is set: go to X_LOCK, cnt = 0.
  - Else if cnt+1 == BURST_MAX and Y is also requesting: go to Y_PRI, cnt = 0.
  - Else: cnt = min(cnt+1, BURST_MAX).
- X_PRI, only Y requesting:
  - Grant Y.
  - If `i_lock_Y` is set: go to Y_LOCK, cnt = 0.
  - Else: go to Y_PRI, cnt = 1.
- X_PRI, no requests: stay in X_PRI, cnt = 0.
- X_LOCK:
  - Only X can be granted. Y is never granted, even while X is idle.
  - A granted X access with `i_lock_X` = 0 releases the lock: go to Y_PRI, cnt = 0.
  - A granted access with lock still set stays in X_LOCK.
- BURST_MAX = 1 gives strict alternation whenever both clients are requesting.
- Read return: a granted read sets the client's rvalid on the next cycle, for exactly one cycle per read. Writes never raise rvalid.
- Back-to-back reads are fully pipelined at one per cycle.
- The other RAM port may write the same address concurrently. Collision results are undefined and the arbiter does not guard against them.

## Timing
- Read latency: grant in cycle N, `o_rvalid_X` and data in cycle N+1.
- Write: the RAM is updated at the clock edge that ends the grant cycle.
- Reset values:
  - State = A_PRI, cnt = 0.
  - `o_rvalid_a` = `o_rvalid_b` = 0, both rdata = 0.
  - While `rst` is high: all gnt outputs = 0, `o_mem_en` = 0, `o_mem_wen` = 0.
- Reset mid-operation:
  - A read granted in the cycle before `rst` rises produces no rvalid.
  - An active lock is dropped.
  - Client requests must be re-presented after reset.
- Simultaneous requests with cnt+1 == BURST_MAX: the current priority owner gets its final grant this cycle, and the switch takes effect on the next cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum encodings (A_PRI = 2'd0, B_PRI = 2'd1, A_LOCK = 2'd2, B_LOCK = 2'd3).
  - Client index constants.
  - Counter width (4).
- Single sub-module `mem_arb_dp_1024x8_ctl`:
  - Contains the state machine and burst counter.
  - Outputs: grant vector and next-state values.
  - The top level holds the port muxes and the rvalid/rdata pipeline.
- The RAM itself is not instantiated in this block; the integrating level connects it.

## Test plan
- Write then read:
  - A writes 0x3C to address 5; A reads address 5.
  - Required: `o_rvalid_a` pulses exactly one cycle after the read grant, `o_rdata_a` = 0x3C, `o_rvalid_b` stays 0.
- Contention, BURST_MAX = 4:
  - Both clients request continuously, each issuing reads.
  - Required grant sequence: A A A A B B B B A…, and rvalid per client tracks its grants with one-cycle lag.
- Single requester:
  - B alone requests 10 reads.
  - Required: 10 consecutive grants, no gaps, cnt saturates and no switch occurs.
- Lock:
  - A reads address 0x3FF with lock = 1 while B requests continuously.
  - A idles 3 cycles, then writes with lock = 0.
  - Required: B gets no grant until the cycle after A's unlocked write; B is then granted first.
- Reset mid-burst:
  - Assert `rst` for one cycle, on the cycle right after A's read grant.
  - Required: `o_rvalid_a` stays 0, gnt and `o_mem_en` are 0 during reset, and A has priority first after reset.
- BURST_MAX = 1:
  - Both clients request continuously.
  - Required: strict A B A B alternation starting with A.
